// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the instruction/data memory port arbiter.
package mem_port_arbiter_pkg;
  localparam logic MEM_READ  = 1'b0;
  localparam logic MEM_WRITE = 1'b1;

  localparam int DEF_MEM_LAT    = 1;
  localparam int DEF_STARVE_MAX = 4;

  typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_LS} owner_t;
  typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_t;
endpackage

// File: rtl/mem_port_arbiter_if.sv
// Fetch, load/store and memory-side signals of the shared memory port.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_flush;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;
  logic              ls_req;
  logic              ls_we;
  logic [ADDR_W-1:0] ls_addr;
  logic [DATA_W-1:0] ls_wdata;
  logic              ls_gnt;
  logic              ls_rvalid;
  logic [DATA_W-1:0] ls_rdata;
  logic              mem_en;
  logic              mem_read_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  // Requesters plus the memory array
  modport master (
    output if_req, if_addr, if_flush, ls_req, ls_we, ls_addr, ls_wdata, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata,
           mem_en, mem_read_write, mem_addr, mem_wdata
  );

  // The arbiter itself
  modport slave (
    input  if_req, if_addr, if_flush, ls_req, ls_we, ls_addr, ls_wdata, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata,
           mem_en, mem_read_write, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter_prio_sel.sv
// Data-priority winner select with a saturating starvation counter for fetch.
module arb_prio_sel #(
  parameter int STARVE_MAX = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic win_en,
  input  logic if_req,
  input  logic ls_req,
  output logic if_win,
  output logic ls_win
);
  localparam logic [3:0] SMAX = 4'(STARVE_MAX);

  logic [3:0] starve_cnt;

  always_comb begin
    if_win = win_en && if_req && (!ls_req || (starve_cnt == SMAX));
    ls_win = win_en && ls_req && !if_win;
  end

  // Once saturated IF is forced to win, which clears the count again
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      starve_cnt <= 4'd0;
    end else if (!if_req || if_win) begin
      starve_cnt <= 4'd0;
    end else if (ls_win && (starve_cnt != SMAX)) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency memory port between fetch and load/store and steers responses.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = DEF_MEM_LAT,
  parameter int STARVE_MAX = DEF_STARVE_MAX
) (
  input  logic clock,
  input  logic reset,
  mem_port_arbiter_if.slave bus
);
  localparam logic [2:0] LAT = 3'(MEM_LAT);

  arb_state_t        state;
  owner_t            owner;
  logic [2:0]        lat_cnt;
  logic              flush_pend;
  logic              store_q;
  logic              complete;
  logic              win_en;
  logic              if_win;
  logic              ls_win;
  logic [ADDR_W-1:0] addr_mux;
  logic [DATA_W-1:0] wdata_mux;

  assign complete = (state == ARB_BUSY) && (lat_cnt == LAT);
  assign win_en   = !reset && ((state == ARB_IDLE) || complete);

  arb_prio_sel #(.STARVE_MAX(STARVE_MAX)) u_prio (
    .clock  (clock),
    .reset  (reset),
    .win_en (win_en),
    .if_req (bus.if_req),
    .ls_req (bus.ls_req),
    .if_win (if_win),
    .ls_win (ls_win)
  );

  // Grant-cycle memory request, driven straight from the winner
  always_comb begin
    addr_mux  = '0;
    wdata_mux = '0;
    if (ls_win) begin
      addr_mux  = bus.ls_addr;
      wdata_mux = bus.ls_wdata;
    end else if (if_win) begin
      addr_mux  = bus.if_addr;
    end
  end

  assign bus.if_gnt         = if_win;
  assign bus.ls_gnt         = ls_win;
  assign bus.mem_en         = if_win || ls_win;
  assign bus.mem_addr       = addr_mux;
  assign bus.mem_wdata      = wdata_mux;
  assign bus.mem_read_write = (ls_win && bus.ls_we) ? MEM_WRITE : MEM_READ;

  // Completion-cycle response steering; a flush seen now or earlier kills the fetch pulse
  assign bus.if_rvalid = !reset && complete && (owner == OWN_IF) && !flush_pend && !bus.if_flush;
  assign bus.ls_rvalid = !reset && complete && (owner == OWN_LS);
  assign bus.if_rdata  = bus.if_rvalid ? bus.mem_rdata : '0;
  assign bus.ls_rdata  = (bus.ls_rvalid && !store_q) ? bus.mem_rdata : '0;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= ARB_IDLE;
      owner      <= OWN_NONE;
      lat_cnt    <= 3'd0;
      flush_pend <= 1'b0;
      store_q    <= 1'b0;
    end else if (if_win || ls_win) begin
      state      <= ARB_BUSY;
      owner      <= if_win ? OWN_IF : OWN_LS;
      lat_cnt    <= 3'd1;
      flush_pend <= if_win && bus.if_flush;
      store_q    <= ls_win && bus.ls_we;
    end else if (complete) begin
      state      <= ARB_IDLE;
      owner      <= OWN_NONE;
      lat_cnt    <= 3'd0;
      flush_pend <= 1'b0;
      store_q    <= 1'b0;
    end else if (state == ARB_BUSY) begin
      lat_cnt <= lat_cnt + 3'd1;
      if ((owner == OWN_IF) && bus.if_flush) flush_pend <= 1'b1;
    end
  end
endmodule
